// File: rtl/player_motion_ctrl.sv
// Player motion controller: turns key levels into a wall- and edge-checked
// player position, one step per movement tick, with per-axis wall sliding.
module player_motion_ctrl #(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int SIZE        = 20,
  parameter int STEP        = 1,
  parameter int CELL_W      = 80,
  parameter int CELL_H      = 60,
  parameter int X0          = 310,
  parameter int Y0          = 230
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        flip_vert,
  input  logic [0:63] grid_is_wall,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        update,
  output logic        blocked
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_SAMPLE,
    S_CHK_X,
    S_CHK_Y,
    S_COMMIT
  } state_e;

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic signed [10:0] XMAX = 11'(640 - SIZE);
  localparam logic signed [10:0] YMAX = 11'(480 - SIZE);
  localparam logic signed [10:0] STP = 11'(STEP);
  localparam logic [9:0] OFS = 10'(SIZE - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic upd_q, upd_d;
  logic blk_q, blk_d;
  logic mx_q, mx_d;
  logic xneg_q, xneg_d;
  logic my_q, my_d;
  logic yneg_q, yneg_d;
  logic [0:63] wall_q, wall_d;
  logic [1:0] ph_q, ph_d;
  logic rej_x_q, rej_x_d;
  logic rej_y_q, rej_y_d;

  logic signed [10:0] cx, cy;
  logic oob_x, oob_y;
  logic [9:0] base_x, base_y;
  logic [9:0] px, py;
  logic hit;

  // Column of a pixel x via a constant comparator ladder
  function automatic logic [2:0] col_of(input logic [9:0] p);
    logic [2:0] c;
    c = '0;
    for (int i = 1; i < 8; i++)
      if (p >= 10'(i * CELL_W)) c = 3'(i);
    return c;
  endfunction

  // Row of a pixel y via a constant comparator ladder
  function automatic logic [2:0] row_of(input logic [9:0] p);
    logic [2:0] r;
    r = '0;
    for (int i = 1; i < 8; i++)
      if (p >= 10'(i * CELL_H)) r = 3'(i);
    return r;
  endfunction

  // Candidate positions, bounds and the corner under test this cycle
  always_comb begin
    cx = xneg_q ? ($signed({1'b0, x_q}) - STP)
                : ($signed({1'b0, x_q}) + STP);
    cy = yneg_q ? ($signed({1'b0, y_q}) - STP)
                : ($signed({1'b0, y_q}) + STP);
    oob_x = (cx < 11'sd0) || (cx > XMAX);
    oob_y = (cy < 11'sd0) || (cy > YMAX);
    base_x = cx[9:0];
    base_y = y_q;
    if (state_q == S_CHK_Y) begin
      base_x = (mx_q && !rej_x_q) ? cx[9:0] : x_q;
      base_y = cy[9:0];
    end
    px = base_x + (ph_q[0] ? OFS : 10'd0);
    py = base_y + (ph_q[1] ? OFS : 10'd0);
    hit = wall_q[{row_of(py), col_of(px)}];
  end

  // Tick counter and move FSM next-state/outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    upd_d   = 1'b0;
    blk_d   = blk_q;
    mx_d    = mx_q;
    xneg_d  = xneg_q;
    my_d    = my_q;
    yneg_d  = yneg_q;
    wall_d  = wall_q;
    ph_d    = ph_q;
    rej_x_d = rej_x_q;
    rej_y_d = rej_y_q;
    unique case (state_q)
      S_WAIT: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        wall_d  = grid_is_wall;
        mx_d    = left ^ right;
        xneg_d  = left;
        my_d    = up;
        yneg_d  = !flip_vert;
        rej_x_d = 1'b0;
        rej_y_d = 1'b0;
        ph_d    = 2'd0;
        if (left ^ right) state_d = S_CHK_X;
        else if (up)      state_d = S_CHK_Y;
        else              state_d = S_WAIT;
      end
      S_CHK_X: begin
        rej_x_d = rej_x_q | oob_x | hit;
        ph_d    = ph_q + 2'd1;
        if (ph_q == 2'd3)
          state_d = my_q ? S_CHK_Y : S_COMMIT;
      end
      S_CHK_Y: begin
        rej_y_d = rej_y_q | oob_y | hit;
        ph_d    = ph_q + 2'd1;
        if (ph_q == 2'd3) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (mx_q && !rej_x_q) x_d = cx[9:0];
        if (my_q && !rej_y_q) y_d = cy[9:0];
        upd_d   = 1'b1;
        blk_d   = (mx_q & rej_x_q) | (my_q & rej_y_q);
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      x_q     <= 10'(X0);
      y_q     <= 10'(Y0);
      upd_q   <= 1'b0;
      blk_q   <= 1'b0;
      mx_q    <= 1'b0;
      xneg_q  <= 1'b0;
      my_q    <= 1'b0;
      yneg_q  <= 1'b0;
      wall_q  <= '0;
      ph_q    <= 2'd0;
      rej_x_q <= 1'b0;
      rej_y_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      upd_q   <= upd_d;
      blk_q   <= blk_d;
      mx_q    <= mx_d;
      xneg_q  <= xneg_d;
      my_q    <= my_d;
      yneg_q  <= yneg_d;
      wall_q  <= wall_d;
      ph_q    <= ph_d;
      rej_x_q <= rej_x_d;
      rej_y_q <= rej_y_d;
    end
  end

  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign update  = upd_q;
  assign blocked = blk_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: scripted scenarios plus random keys/maps,
// expected moves queued from a cell-overlap reference model.
module tb_player_motion_ctrl;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic        up = 1'b0;
  logic        flip_vert = 1'b0;
  logic [0:63] grid = '0;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        update;
  logic        blocked;

  always #5 clk = ~clk;

  player_motion_ctrl #(.TICK_CYCLES(TICK)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .left         (left),
    .right        (right),
    .up           (up),
    .flip_vert    (flip_vert),
    .grid_is_wall (grid),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .update       (update),
    .blocked      (blocked)
  );

  typedef struct {
    int x;
    int y;
    bit blk;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   mdl_x = 310;
  int   mdl_y = 230;
  int   last_x = 0;
  int   last_y = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Does a SIZE=20 square at (x,y) overlap any wall cell?
  function automatic bit hits(input logic [0:63] m, input int x, input int y);
    for (int r = y / 60; r <= (y + 19) / 60; r++)
      for (int c = x / 80; c <= (x + 19) / 80; c++)
        if (m[r * 8 + c]) return 1'b1;
    return 1'b0;
  endfunction

  // One movement tick of the player from the rules, axis by axis
  task automatic model(input int x, input int y, input bit l, input bit r,
                       input bit u, input bit f, input logic [0:63] m,
                       output int nx, output int ny, output bit blk,
                       output int na);
    int dx, dy, cx, cy;
    dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    dy = u ? (f ? 1 : -1) : 0;
    nx = x; ny = y; blk = 1'b0;
    na = (dx != 0 ? 1 : 0) + (dy != 0 ? 1 : 0);
    if (dx != 0) begin
      cx = x + dx;
      if (cx < 0 || cx > 620 || hits(m, cx, y)) blk = 1'b1;
      else nx = cx;
    end
    if (dy != 0) begin
      cy = y + dy;
      if (cy < 0 || cy > 460 || hits(m, nx, cy)) blk = 1'b1;
      else ny = cy;
    end
  endtask

  // Monitor: pop expected result on every update; outputs otherwise hold
  always @(negedge clk) begin
    if (rst) begin
      if (update) begin
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_update: x=%0d y=%0d, required no pulse",
                   x_pos, y_pos);
        end else begin
          e = sbq.pop_front();
          if (int'(x_pos) == e.x && int'(y_pos) == e.y && blocked == e.blk)
            passes++;
          else
            $display("FAIL move: got x=%0d y=%0d blk=%0d, required x=%0d y=%0d blk=%0d",
                     x_pos, y_pos, blocked, e.x, e.y, e.blk);
        end
      end else begin
        check("hold_x", int'(x_pos), last_x);
        check("hold_y", int'(y_pos), last_y);
      end
    end
    last_x = int'(x_pos);
    last_y = int'(y_pos);
  end

  // Apply keys/map for one tick; called at a negedge with the tick counter at 0
  task automatic do_step(input bit l, input bit r, input bit u, input bit f,
                         input logic [0:63] m, input bit scr);
    int nx, ny, na, nc;
    bit b, got, seen;
    left = l; right = r; up = u; flip_vert = f; grid = m;
    model(mdl_x, mdl_y, l, r, u, f, m, nx, ny, b, na);
    if (na > 0) begin
      sbq.push_back('{nx, ny, b});
      mdl_x = nx;
      mdl_y = ny;
      got = 1'b0;
      nc = 0;
      for (int k = 1; k <= 60 && !got; k++) begin
        @(negedge clk);
        if (scr && k == TICK + 1) begin
          left = ~l; right = ~r; up = ~u; flip_vert = ~f; grid = ~m;
        end
        if (update) begin
          got = 1'b1;
          nc = k;
        end
      end
      check("update_seen", int'(got), 1);
      if (got) check("latency", nc, TICK + 2 + 4 * na);
    end else begin
      seen = 1'b0;
      repeat (2 * TICK + 8) begin
        @(negedge clk);
        if (update) seen = 1'b1;
      end
      check("no_update_cancel", int'(seen), 0);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
    end
  endtask

  initial begin
    logic [0:63] w;
    logic [0:63] rm;
    bit seen;

    // T1 reset
    repeat (3) @(negedge clk);
    check("rst_x", int'(x_pos), 310);
    check("rst_y", int'(y_pos), 230);
    check("rst_update", int'(update), 0);
    check("rst_blocked", int'(blocked), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_x", int'(x_pos), 310);
    check("post_rst_y", int'(y_pos), 230);

    // T2 open moves
    enable = 1'b1;
    repeat (3) do_step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("t2_x", int'(x_pos), 313);
    check("t2_blocked", int'(blocked), 0);

    // Walk to (300,190)
    repeat (13) do_step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (27) do_step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("nav_x", int'(x_pos), 300);
    check("nav_y", int'(y_pos), 190);

    // T3 wall stop
    w = '0;
    w[3 * 8 + 4] = 1'b1;
    do_step(1'b0, 1'b1, 1'b0, 1'b0, w, 1'b0);
    do_step(1'b0, 1'b1, 1'b0, 1'b0, w, 1'b1);
    check("t3_x", int'(x_pos), 300);
    check("t3_blocked", int'(blocked), 1);

    // T4 slide along the wall, then clear it
    repeat (35) do_step(1'b0, 1'b1, 1'b1, 1'b0, w, 1'($urandom % 2));
    check("t4_x", int'(x_pos), 305);
    check("t4_y", int'(y_pos), 155);
    check("t4_blocked", int'(blocked), 0);

    // T5 screen edges and cancel
    while (mdl_x > 0 || mdl_y < 460)
      do_step(mdl_x > 0, 1'b0, mdl_y < 460, 1'b1, '0, 1'b0);
    do_step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("t5_left_x", int'(x_pos), 0);
    check("t5_left_blocked", int'(blocked), 1);
    do_step(1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    check("t5_down_y", int'(y_pos), 460);
    do_step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // T6 enable low holds
    enable = 1'b0;
    left = 1'b0; right = 1'b1; up = 1'b0; grid = '0;
    seen = 1'b0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (update) seen = 1'b1;
    end
    check("t6_disabled", int'(seen), 0);

    // T6 reset during CHK_X
    enable = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_x", int'(x_pos), 310);
    check("t6_rst_y", int'(y_pos), 230);
    check("t6_rst_update", int'(update), 0);
    sbq.delete();
    mdl_x = 310;
    mdl_y = 230;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (update) seen = 1'b1;
    end
    check("t6_no_commit", int'(seen), 0);
    check("t6_hold_x", int'(x_pos), 310);

    // Random keys and sparse random maps
    enable = 1'b1;
    repeat (60) begin
      for (int i = 0; i < 64; i++) rm[i] = ($urandom_range(0, 9) == 0);
      do_step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
              1'($urandom % 2), rm, 1'($urandom % 2));
    end

    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
